reg_file_rw: RTL and testbench
==============================

Name: reg_file_rw

Overview:
Architectural register file for the single-cycle core, built as the direct consumer of the per-bit storage cells.
- Two combinational read ports, one synchronous write port, and same-cycle write-to-read bypass.
- A handshaked clear sequencer zeroes the bank one register per cycle for context reset.
- Sits between decode (read addresses) and writeback (write port); read data feeds the ALU operand muxes.

Parameters:
- WIDTH, 16, data width of each register in bits.
- NUM_REGS, 16, number of registers; must be a power of two.
- ADDR_W, 4, register address width; equals log2(NUM_REGS).
- ZERO_REG, 1, 1 = register 0 is hardwired to zero (writes to it are dropped).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- raddr1  in  ADDR_W  read port 1 address.
- raddr2  in  ADDR_W  read port 2 address.
- rdata1  out  WIDTH  read port 1 data (combinational).
- rdata2  out  WIDTH  read port 2 data (combinational).
- wen  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- clr_req  in  1  request a full-bank clear; sampled only in IDLE.
- ready  out  1  1 = bank accepts writes and clr_req.
- clr_done  out  1  one-cycle pulse at clear completion.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on rst.
  - All registers go to 0, FSM to IDLE, clear counter to 0.
  - ready=1, clr_done=0; rdata1/rdata2 read 0.
  - Reset asserted mid-clear aborts the sequence immediately. No clr_done pulse is produced.
- Write:
  - In IDLE with wen=1, reg[waddr] <= wdata at the rising edge.
  - If ZERO_REG=1 and waddr=0, the write is dropped.
- Read:
  - rdata = reg[raddr], combinational, zero-cycle latency.
  - Bypass: in IDLE, if wen=1, waddr==raddr and the write is not dropped, rdata=wdata in the same cycle.
  - Each port bypasses independently. Both ports may hit the same address.
  - If ZERO_REG=1 and raddr=0, rdata=0 always, including when wen=1 and waddr=0.
- FSM:
  - IDLE: if clr_req=1 at an edge, go to CLEAR with cnt=0. ready drops to 0 after that edge.
  - CLEAR: at each edge reg[cnt] <= 0 and cnt <= cnt+1. At the edge where cnt==NUM_REGS-1, that register is cleared, FSM returns to IDLE, and clr_done=1 for the following cycle.
  - Clear takes exactly NUM_REGS cycles. ready returns to 1 in the same cycle clr_done is high.
- Boundary conditions:
  - wen during CLEAR is ignored; no write, no bypass.
  - clr_req during CLEAR is ignored; no re-queue.
  - clr_req and wen in the same IDLE cycle: the write commits at that edge, and CLEAR starts at that edge. The cleared value wins by the end of the sequence.
  - Reads during CLEAR return current storage (already-cleared registers read 0).
  - cnt wraps to 0 on exit. No out-of-range index is ever generated.
- Storage is plain flops with async reset. No tristate bitlines inside this block; the read muxes are explicit.

Decomposition:
- Shared package/header reg_file_pkg:
  - WIDTH, NUM_REGS and ADDR_W defaults.
  - FSM state encodings ST_IDLE=1'b0, ST_CLEAR=1'b1.
  - ZERO_REG default.
- One sub-module, reg_read_port, instantiated twice. Inputs: storage array (flattened), raddr, bypass qualifier (wen & idle & not-dropped), waddr, wdata. Output: rdata. It contains the address mux, bypass compare and zero-register override.
- FSM, counter and write decode stay in the top.

Test Plan:
- Reset then read all regs: assert rst=0 mid-cycle, release → all 16 addresses read 0x0000 on both ports, ready=1, clr_done=0.
- Write then read: wen=1, waddr=5, wdata=0xBEEF; next cycle raddr1=5 → rdata1=0xBEEF. Same cycle with raddr2=5 → rdata2=0xBEEF via bypass while storage still holds 0.
- Zero register: wen=1, waddr=0, wdata=0x1234 with raddr1=0 → rdata1=0 in that cycle and all later cycles.
- Clear sequence: load regs 1..15 with 0x1000+i, pulse clr_req.
  - ready=0 for 16 cycles.
  - After k edges, regs 0..k-1 read 0 and others keep their values.
  - clr_done is high for exactly one cycle when ready returns to 1.
  - wen=1 to reg 3 during CLEAR has no effect.
- Simultaneous clr_req and wen (waddr=7, wdata=0xAAAA) in IDLE → reg 7 reads 0xAAAA until the clear reaches it, then reads 0.
- Reset mid-clear: assert rst=0 after 5 clear cycles → immediately all regs 0, ready=1. No clr_done pulse before or after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and FSM encoding for the register file
package reg_file_pkg;

  localparam int RF_WIDTH    = 16;
  localparam int RF_NUM_REGS = 16;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_ZERO_REG = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - combinational read mux with write bypass and zero-register override
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic [NUM_REGS*WIDTH-1:0] regs_flat,
  input  logic [ADDR_W-1:0]         raddr,
  input  logic                      byp_en,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata
);

  // The zero-register override is applied last so it beats any bypass hit.
  always_comb begin
    rdata = regs_flat[raddr*WIDTH +: WIDTH];
    if (byp_en && (waddr == raddr)) begin
      rdata = wdata;
    end
    if ((ZERO_REG != 0) && (raddr == '0)) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/reg_file_rw.sv
// rtl/reg_file_rw.sv - two-read one-write register file with bypass and sequenced clear
module reg_file_rw
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              clr_req,
  output logic              ready,
  output logic              clr_done
);

  state_t                    state;
  logic [ADDR_W-1:0]         cnt;
  logic [WIDTH-1:0]          regs [NUM_REGS];
  logic [NUM_REGS*WIDTH-1:0] regs_flat;
  logic                      idle;
  logic                      drop;
  logic                      wr_ok;

  assign idle  = (state == ST_IDLE);
  assign drop  = (ZERO_REG != 0) && (waddr == '0);
  assign wr_ok = idle && wen && !drop;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      state    <= ST_IDLE;
      cnt      <= '0;
      ready    <= 1'b1;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A write coinciding with clr_req still commits; the clear overwrites it later.
          if (wr_ok) begin
            regs[waddr] <= wdata;
          end
          if (clr_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
        ST_CLEAR: begin
          regs[cnt] <= '0;
          cnt       <= cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(NUM_REGS - 1)) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            clr_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  reg_read_port #(
    .WIDTH   (WIDTH),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rd1 (
    .regs_flat(regs_flat),
    .raddr    (raddr1),
    .byp_en   (wr_ok),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata1)
  );

  reg_read_port #(
    .WIDTH   (WIDTH),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rd2 (
    .regs_flat(regs_flat),
    .raddr    (raddr2),
    .byp_en   (wr_ok),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_reg_file_rw.sv
// tb/tb_reg_file_rw.sv - directed self-checking bench for reg_file_rw
module tb_reg_file_rw;

  logic        clk;
  logic        rst;
  logic [3:0]  raddr1;
  logic [3:0]  raddr2;
  logic [15:0] rdata1;
  logic [15:0] rdata2;
  logic        wen;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        clr_req;
  logic        ready;
  logic        clr_done;

  int total;
  int bad;

  reg_file_rw dut (
    .clk     (clk),
    .rst     (rst),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .clr_req (clr_req),
    .ready   (ready),
    .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wen   = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    wen   = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    raddr1  = '0;
    raddr2  = '0;
    wen     = 1'b0;
    waddr   = '0;
    wdata   = '0;
    clr_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;

    for (int a = 0; a < 16; a++) begin
      raddr1 = 4'(a);
      raddr2 = 4'(a);
      #1;
      chk($sformatf("rst_rd1_%0d", a), 32'(rdata1), 32'h0);
      chk($sformatf("rst_rd2_%0d", a), 32'(rdata2), 32'h0);
    end
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_clr_done", 32'(clr_done), 32'h0);

    // write with same-cycle bypass on port 2
    raddr1 = 4'd6;
    raddr2 = 4'd5;
    wen    = 1'b1;
    waddr  = 4'd5;
    wdata  = 16'hBEEF;
    #1;
    chk("byp_rd2", 32'(rdata2), 32'hBEEF);
    chk("byp_other_rd1", 32'(rdata1), 32'h0);
    tick();
    wen    = 1'b0;
    raddr1 = 4'd5;
    #1;
    chk("wr_rd1", 32'(rdata1), 32'hBEEF);
    chk("wr_rd2", 32'(rdata2), 32'hBEEF);

    // zero register
    raddr1 = 4'd0;
    wen    = 1'b1;
    waddr  = 4'd0;
    wdata  = 16'h1234;
    #1;
    chk("zero_byp", 32'(rdata1), 32'h0);
    tick();
    wen = 1'b0;
    #1;
    chk("zero_after", 32'(rdata1), 32'h0);

    for (int i = 1; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
    raddr1 = 4'd15;
    raddr2 = 4'd1;
    #1;
    chk("load_r15", 32'(rdata1), 32'h100F);
    chk("load_r1", 32'(rdata2), 32'h1001);

    // full clear, with a write to reg 3 attempted mid-sequence
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      raddr2 = 4'(k);
      raddr1 = (k > 0) ? 4'(k - 1) : 4'd0;
      if (k == 1) begin
        wen   = 1'b1;
        waddr = 4'd3;
        wdata = 16'hFFFF;
      end else begin
        wen = 1'b0;
      end
      #1;
      chk($sformatf("clr_ready_%0d", k), 32'(ready), 32'h0);
      chk($sformatf("clr_done_%0d", k), 32'(clr_done), 32'h0);
      chk($sformatf("clr_prev_%0d", k), 32'(rdata1), 32'h0);
      chk($sformatf("clr_keep_%0d", k), 32'(rdata2), (k == 0) ? 32'h0 : 32'h1000 + 32'(k));
      tick();
    end
    wen = 1'b0;
    chk("clr_end_ready", 32'(ready), 32'h1);
    chk("clr_end_done", 32'(clr_done), 32'h1);
    for (int a = 0; a < 16; a++) begin
      raddr1 = 4'(a);
      #1;
      chk($sformatf("clr_all_%0d", a), 32'(rdata1), 32'h0);
    end
    tick();
    chk("clr_done_pulse", 32'(clr_done), 32'h0);
    chk("clr_ready_hold", 32'(ready), 32'h1);

    // simultaneous write and clear request
    raddr1  = 4'd7;
    wen     = 1'b1;
    waddr   = 4'd7;
    wdata   = 16'hAAAA;
    clr_req = 1'b1;
    #1;
    chk("sim_byp", 32'(rdata1), 32'hAAAA);
    tick();
    wen     = 1'b0;
    clr_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("sim_r7_%0d", k), 32'(rdata1), (k < 8) ? 32'hAAAA : 32'h0);
      tick();
    end
    chk("sim_done", 32'(clr_done), 32'h1);
    tick();

    // reset in the middle of a clear
    wr(4'd9, 16'h5555);
    wr(4'd2, 16'h2222);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    raddr1 = 4'd9;
    raddr2 = 4'd2;
    #1;
    chk("mid_r9_pre", 32'(rdata1), 32'h5555);
    chk("mid_r2_pre", 32'(rdata2), 32'h0);
    chk("mid_ready_pre", 32'(ready), 32'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_r9_rst", 32'(rdata1), 32'h0);
    chk("mid_ready_rst", 32'(ready), 32'h1);
    chk("mid_done_rst", 32'(clr_done), 32'h0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("post_done_%0d", k), 32'(clr_done), 32'h0);
      chk($sformatf("post_ready_%0d", k), 32'(ready), 32'h1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
